r30_entropy_stream: RTL and testbench
=====================================

# r30_entropy_stream

Sequential harvesting stage wrapped around the combinational `R30EntropyGen` (Rule 30 cellular-automaton step). Holds the N-bit automaton state in a register and advances it one generation per active cycle. Collects the tap (centre) cell of each generation into W-bit words and delivers them downstream over a valid/ready stream. Also accepts reseeds and recovers from the all-zero lock-up state.

## Interface
- `N`, 128: automaton width; must be ≥ 8, even.
- `W`, 32: output word width, 1 ≤ W ≤ N.
- `TAP`, N/2: state bit harvested each generation.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `enable` in 1: when low, no stepping; the state is frozen.
- `seed_valid` in 1: load request.
- `seed` in N: new automaton state.
- `seed_ready` out 1: 1 in every cycle except while `rst_n` is low.
- `out_valid` out 1: `out_data` holds an undelivered word.
- `out_ready` in 1: downstream accepts a word.
- `out_data` out W: harvested word; first-harvested bit is in the MSB.
- `zero_reseed` out 1: one-cycle pulse when the all-zero state was replaced.

## Operation
- Registers:
  - `state[N-1:0]`
  - accumulator `acc[W-1:0]`
  - counter `cnt`, width clog2(W)+1
  - output register `out_data`/`out_valid`.
- `next = R30EntropyGen(state)`: `next[i] = state[(i+1) mod N] ^ (state[i] | state[(i-1) mod N])`, periodic boundary.
- `DEFAULT_SEED` is all-zero except bit N/2.
- Step condition: `enable && !load && !stall`.
  - `load = seed_valid` (`seed_ready` is 1).
  - `stall = (cnt == W-1) && out_valid && !out_ready`.
- On a step:
  - `acc <= {acc[W-2:0], state[TAP]}`.
  - `state <= (next == 0) ? DEFAULT_SEED : next`; `zero_reseed` pulses in that case.
  - If `cnt == W-1`: `out_data <= {acc[W-2:0], state[TAP]}`, `out_valid <= 1`, `cnt <= 0`. Otherwise `cnt <= cnt + 1`.
- Output handshake:
  - A word transfers on `out_valid && out_ready`.
  - If no new word completes in the same cycle, `out_valid <= 0`.
  - If a word completes in the same cycle, it replaces the old one and `out_valid` stays 1.
  - `out_data` is stable while `out_valid && !out_ready`.
- Load, which takes priority over a step:
  - `state <= (seed == 0) ? DEFAULT_SEED : seed`; `zero_reseed` pulses if `seed == 0`.
  - `cnt <= 0`, `acc <= 0`.
  - A pending output word is kept, and may still transfer that cycle.
- FSM, derived from the conditions above:
  - RUN: `enable` high and not stalled.
  - HOLD: `enable` low; `cnt`/`acc` are preserved. Output draining still works.
  - STALL: word complete and output full. Exits to RUN on the cycle `out_ready` is seen.
- Reset values:
  - `state = DEFAULT_SEED`
  - `cnt = 0`, `acc = 0`
  - `out_valid = 0`, `out_data = 0`
  - `zero_reseed = 0`, `seed_ready = 0`
- Reset asserted mid-word or with a pending word discards everything immediately (asynchronous).

## Timing
- One generation per cycle in RUN. Throughput is one word per W cycles while `out_ready` is held high.
- Latency after reset release, with `enable` high: `out_valid` rises after the W-th rising edge.
- After a load on edge k, the first word appears after edge k+W (no stalls or holds).
- Stall costs exactly the cycles `out_ready` stays low; no generation is lost or duplicated.
- All outputs are registered. There is no combinational path from `out_ready` or `seed_valid` to `out_valid` or `out_data`.

## Structure
- Shared package `r30_pkg`:
  - `R30_N_DEFAULT = 128`
  - `R30_W_DEFAULT = 32`
  - `r30_default_seed(N)` function
  - state enum `{RUN, HOLD, STALL}`
- Sub-module: one instance of `R30EntropyGen #(.N(N))`, used unmodified. All sequencing lives in `r30_entropy_stream`.

## Test plan
- Reset then `enable=1`, `out_ready=1`, W=32 → first word after edge 32.
  - `out_data[31:24] = 8'hDC` (centre column 1,1,0,1,1,1,0,0).
  - Full word matches a software Rule 30 model.
  - Next words follow every 32 cycles.
- Hold `out_ready=0` for 100 cycles after the first word →
  - `out_valid` stays 1 with stable data.
  - Stepping stops with `cnt == 31`.
  - After release, the next word equals the model output with no skipped generations.
- Load `seed = 0` mid-word (cnt = 13) →
  - `zero_reseed` pulses for one cycle and the state equals `DEFAULT_SEED`.
  - The next word is `0xDC…`, as after reset.
  - The pending word is still delivered.
- `seed_valid` and a word completion in the same cycle → load wins, no word is produced, and `cnt` returns to 0.
- `enable` toggled low for 5 cycles at cnt = 7 → the word equals the uninterrupted model word and is delayed by 5 cycles.
- Assert `rst_n` low mid-word with `out_valid = 1` → outputs go to their reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/r30_entropy_stream_pkg.sv
// Shared definitions for the Rule 30 entropy harvester: default sizes,
// default seed helper and the sequencing state enum.
package r30_pkg;

   localparam int R30_N_DEFAULT = 128;
   localparam int R30_W_DEFAULT = 32;
   localparam int R30_MAX_N     = 1024;

   typedef enum logic [1:0] {RUN, HOLD, STALL} r30_mode_e;

   // Single live cell in the middle; callers keep the low n bits.
   function automatic logic [R30_MAX_N-1:0] r30_default_seed(input int n);
      logic [R30_MAX_N-1:0] s;
      s = {{(R30_MAX_N-1){1'b0}}, 1'b1} << (n / 2);
      return s;
   endfunction

endpackage

// File: rtl/r30_entropy_stream_gen.sv
// One Rule 30 generation over an N-cell ring:
// new[i] = left ^ (self | right) with periodic wrap-around.
module R30EntropyGen #(
   parameter int N = 128
) (
   input  logic [N-1:0] state,
   output logic [N-1:0] next_state
);

   for (genvar i = 0; i < N; i++) begin : g_cell
      assign next_state[i] = state[(i + 1) % N] ^ (state[i] | state[(i + N - 1) % N]);
   end

endmodule

// File: rtl/r30_entropy_stream.sv
// Rule 30 harvesting stage: steps the automaton, packs the tap cell into
// W-bit words (first bit in the MSB) and streams them out over valid/ready.
module r30_entropy_stream
   import r30_pkg::*;
#(
   parameter int N   = R30_N_DEFAULT,
   parameter int W   = R30_W_DEFAULT,
   parameter int TAP = N / 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         enable,
   input  logic         seed_valid,
   input  logic [N-1:0] seed,
   output logic         seed_ready,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data,
   output logic         zero_reseed
);

   localparam int CW = $clog2(W) + 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);
   localparam logic [R30_MAX_N-1:0] SEED_FULL = r30_default_seed(N);
   localparam logic [N-1:0] DEFAULT_SEED = SEED_FULL[N-1:0];

   logic [N-1:0]  state, state_d, next_gen;
   logic [W-1:0]  acc, acc_d, shifted, out_data_d;
   logic [CW-1:0] cnt, cnt_d;
   logic          out_valid_d, zero_d;
   logic          load, stall, step;
   r30_mode_e     mode, mode_d;

   R30EntropyGen #(.N(N)) u_gen (
      .state      (state),
      .next_state (next_gen)
   );

   if (W > 1) begin : g_shift
      assign shifted = {acc[W-2:0], state[TAP]};
   end else begin : g_bit
      assign shifted = state[TAP];
   end

   // Loads are accepted in every cycle out of reset.
   assign seed_ready = rst_n;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= DEFAULT_SEED;
         acc         <= '0;
         cnt         <= '0;
         out_data    <= '0;
         out_valid   <= 1'b0;
         zero_reseed <= 1'b0;
         mode        <= RUN;
      end else begin
         state       <= state_d;
         acc         <= acc_d;
         cnt         <= cnt_d;
         out_data    <= out_data_d;
         out_valid   <= out_valid_d;
         zero_reseed <= zero_d;
         mode        <= mode_d;
      end
   end

   // STALL is held exactly while the last bit of a word is due and the
   // output register is still occupied, so only out_ready decides the stall.
   always_comb begin
      state_d     = state;
      acc_d       = acc;
      cnt_d       = cnt;
      out_data_d  = out_data;
      out_valid_d = out_valid && !out_ready;
      zero_d      = 1'b0;
      mode_d      = mode;
      load        = seed_valid;
      stall       = (mode == STALL) && !out_ready;
      step        = enable && !load && !stall;

      if (load) begin
         state_d = (seed == '0) ? DEFAULT_SEED : seed;
         zero_d  = (seed == '0);
         cnt_d   = '0;
         acc_d   = '0;
      end else if (step) begin
         acc_d   = shifted;
         state_d = (next_gen == '0) ? DEFAULT_SEED : next_gen;
         zero_d  = (next_gen == '0);
         if (cnt == CNT_LAST) begin
            out_data_d  = shifted;
            out_valid_d = 1'b1;
            cnt_d       = '0;
         end else begin
            cnt_d = cnt + 1'b1;
         end
      end

      if ((cnt_d == CNT_LAST) && out_valid_d) begin
         mode_d = STALL;
      end else if (!enable) begin
         mode_d = HOLD;
      end else begin
         mode_d = RUN;
      end
   end

endmodule

// File: tb/tb_r30_entropy_stream.sv
// Randomized and directed checking of r30_entropy_stream against a
// bit-level behavioural model of the harvester.
module tb_r30_entropy_stream;

   localparam int N   = 128;
   localparam int W   = 32;
   localparam int TAP = N / 2;
   localparam logic [N-1:0] DEF = {{63{1'b0}}, 1'b1, {64{1'b0}}};

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         enable = 1'b0;
   logic         seed_valid = 1'b0;
   logic [N-1:0] seed = '0;
   logic         seed_ready;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] out_data;
   logic         zero_reseed;

   int checks = 0;
   int errors = 0;

   logic [N-1:0] m_state;
   logic [W-1:0] m_acc, m_word;
   int           m_bits;
   bit           m_valid, m_zr;
   int           m_delivered;

   r30_entropy_stream #(.N(N), .W(W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .enable      (enable),
      .seed_valid  (seed_valid),
      .seed        (seed),
      .seed_ready  (seed_ready),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .zero_reseed (zero_reseed)
   );

   always #5 clk = ~clk;

   function automatic logic [N-1:0] rule30(input logic [N-1:0] s);
      logic [N-1:0] n;
      for (int i = 0; i < N; i++)
         n[i] = s[(i + 1) % N] ^ (s[i] | s[(i + N - 1) % N]);
      return n;
   endfunction

   function automatic logic [N-1:0] randSeed();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic checkValue(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic timeoutFail(input string name);
      checks++;
      errors++;
      $display("[TB] FAIL %s timeout actual=expired expected=reached", name);
   endtask

   // Model: counts harvested bits per word rather than tracking a counter state.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_state = DEF;
         m_acc   = '0;
         m_word  = '0;
         m_bits  = 0;
         m_valid = 0;
         m_zr    = 0;
      end else begin
         bit do_load, do_step;
         logic [N-1:0] nx;
         do_load = seed_valid;
         do_step = enable && !do_load && !(m_bits == W - 1 && m_valid && !out_ready);
         if (m_valid && out_ready) begin
            m_valid = 0;
            m_delivered++;
         end
         m_zr = 0;
         if (do_load) begin
            m_state = (seed == '0) ? DEF : seed;
            m_zr    = (seed == '0);
            m_bits  = 0;
            m_acc   = '0;
         end else if (do_step) begin
            m_acc = {m_acc[W-2:0], m_state[TAP]};
            m_bits++;
            nx = rule30(m_state);
            if (nx == '0) begin
               nx   = DEF;
               m_zr = 1;
            end
            m_state = nx;
            if (m_bits == W) begin
               m_word  = m_acc;
               m_valid = 1;
               m_bits  = 0;
            end
         end
      end
   end

   task automatic checkOutput();
      checkValue("out_valid", 128'(out_valid), 128'(m_valid));
      if (m_valid) checkValue("out_data", 128'(out_data), 128'(m_word));
      checkValue("zero_reseed", 128'(zero_reseed), 128'(m_zr));
      checkValue("seed_ready", 128'(seed_ready), 128'(1'b1));
   endtask

   always @(negedge clk) begin
      if (rst_n) checkOutput();
   end

   task automatic applyStimulus(input bit en, input bit rdy, input bit sv, input logic [N-1:0] sd);
      enable     = en;
      out_ready  = rdy;
      seed_valid = sv;
      seed       = sd;
   endtask

   task automatic waitBits(input int target, input int budget, input string name);
      int k = 0;
      while (m_bits != target && k < budget) begin
         @(negedge clk);
         k++;
      end
      if (m_bits != target) timeoutFail(name);
   endtask

   initial begin
      int k;
      logic [N-1:0] sd;
      m_delivered = 0;

      checkValue("model_rule30_default", 128'(rule30(DEF)), 128'h7 << 63);
      checkValue("model_rule30_ones", 128'(rule30({N{1'b1}})), 128'h0);

      applyStimulus(0, 0, 0, '0);
      repeat (3) @(negedge clk);
      checkValue("reset_out_valid", 128'(out_valid), 128'h0);
      checkValue("reset_out_data", 128'(out_data), 128'h0);
      checkValue("reset_seed_ready", 128'(seed_ready), 128'h0);
      checkValue("reset_zero_reseed", 128'(zero_reseed), 128'h0);

      rst_n = 1'b1;
      applyStimulus(1, 1, 0, '0);
      repeat (31) @(posedge clk);
      #1 checkValue("first_word_early", 128'(out_valid), 128'h0);
      @(posedge clk);
      #1 checkValue("first_word_valid", 128'(out_valid), 128'h1);
      checkValue("first_word_top", 128'(out_data[31:24]), 128'hDC);
      checkValue("model_first_top", 128'(m_word[31:24]), 128'hDC);

      @(negedge clk);
      repeat (95) @(negedge clk);
      applyStimulus(1, 0, 0, '0);
      repeat (100) @(negedge clk);
      checkValue("stall_cnt", 128'(dut.cnt), 128'd31);
      checkValue("stall_valid", 128'(out_valid), 128'h1);
      applyStimulus(1, 1, 0, '0);
      repeat (70) @(negedge clk);

      // Zero seed mid-word: pulse, default restart, fresh 0xDC word.
      waitBits(13, 100, "wait_bits13");
      applyStimulus(1, 1, 1, '0);
      @(negedge clk);
      checkValue("zero_seed_pulse", 128'(zero_reseed), 128'h1);
      applyStimulus(1, 1, 0, '0);
      @(negedge clk);
      checkValue("zero_seed_pulse_end", 128'(zero_reseed), 128'h0);
      repeat (30) @(negedge clk);
      checkValue("reseed_word_early", 128'(out_valid), 128'h0);
      @(negedge clk);
      checkValue("reseed_word_valid", 128'(out_valid), 128'h1);
      checkValue("reseed_word_top", 128'(out_data[31:24]), 128'hDC);

      waitBits(W - 1, 100, "wait_bits31");
      applyStimulus(1, 1, 1, randSeed() | 1);
      @(negedge clk);
      checkValue("load_wins_cnt", 128'(dut.cnt), 128'h0);
      checkValue("load_wins_valid", 128'(out_valid), 128'h0);
      applyStimulus(1, 1, 0, '0);

      waitBits(7, 100, "wait_bits7");
      applyStimulus(0, 1, 0, '0);
      repeat (5) @(negedge clk);
      checkValue("hold_cnt", 128'(dut.cnt), 128'd7);
      applyStimulus(1, 1, 0, '0);
      repeat (40) @(negedge clk);

      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         case ($urandom_range(0, 9))
            0:       sd = '0;
            1:       sd = {N{1'b1}};
            default: sd = randSeed();
         endcase
         applyStimulus($urandom_range(0, 9) != 0, $urandom_range(0, 9) < 7,
                       $urandom_range(0, 99) < 2, sd);
      end

      @(negedge clk);
      applyStimulus(1, 0, 0, '0);
      k = 0;
      while (!m_valid && k < 100) begin
         @(negedge clk);
         k++;
      end
      if (!m_valid) timeoutFail("wait_pending_word");
      #2 rst_n = 1'b0;
      #1;
      checkValue("async_out_valid", 128'(out_valid), 128'h0);
      checkValue("async_out_data", 128'(out_data), 128'h0);
      checkValue("async_seed_ready", 128'(seed_ready), 128'h0);
      checkValue("async_zero_reseed", 128'(zero_reseed), 128'h0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(1, 1, 0, '0);
      repeat (40) @(negedge clk);
      checkValue("words_delivered", 128'(m_delivered > 20), 128'h1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
